// File: rtl/sram_pkg.sv
// Shared types and constants for the multi-port asynchronous SRAM controller.
package sram_pkg;

    localparam int DATA_W     = 16;
    localparam int BE_W       = 2;
    localparam int DEF_ADDR_W = 20;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WR      = 2'd1,
        ST_WR_HOLD = 2'd2,
        ST_RD      = 2'd3
    } state_t;

    // Pointer width that stays legal for a single-channel build.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sram_rr_arbiter.sv
// Round-robin selector: searches upward from the channel after ptr and returns a one-hot winner.
module sram_rr_arbiter
    import sram_pkg::*;
#(
    parameter  int NUM_CH = 2,
    localparam int PTR_W  = ptr_width(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [PTR_W-1:0]  ptr,
    output logic [NUM_CH-1:0] winner
);

    logic             found_s;
    logic [PTR_W-1:0] idx_s;

    // First requester found after ptr, wrapping modulo NUM_CH.
    always_comb begin
        winner  = '0;
        found_s = 1'b0;
        idx_s   = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            idx_s = PTR_W'((int'(ptr) + i) % NUM_CH);
            if (!found_s && req[idx_s]) begin
                winner[idx_s] = 1'b1;
                found_s       = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/sram_multiport_ctrl.sv
// Multi-requester controller for a 16-bit asynchronous SRAM: round-robin arbitration,
// one-cycle write strobe with a data hold cycle, and single-cycle reads.
module sram_multiport_ctrl
    import sram_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic                     iCLK,
    input  logic                     iRST_N,
    input  logic [NUM_CH-1:0]        iREQ,
    input  logic [NUM_CH-1:0]        iWE,
    input  logic [NUM_CH*ADDR_W-1:0] iADDR,
    input  logic [NUM_CH*DATA_W-1:0] iWDATA,
    input  logic [NUM_CH*BE_W-1:0]   iBE,
    output logic [NUM_CH-1:0]        oGNT,
    output logic [DATA_W-1:0]        oRDATA,
    output logic [NUM_CH-1:0]        oRD_VALID,
    output logic [ADDR_W-1:0]        oSRAM_ADDR,
    inout  wire  [DATA_W-1:0]        ioSRAM_DQ,
    output logic                     oSRAM_WE_N,
    output logic                     oSRAM_OE_N,
    output logic                     oSRAM_CE_N,
    output logic                     oSRAM_UB_N,
    output logic                     oSRAM_LB_N
);

    localparam int               PTR_W   = ptr_width(NUM_CH);
    localparam logic [PTR_W-1:0] PTR_RST = PTR_W'(NUM_CH - 1);

    state_t              state_r;
    logic [PTR_W-1:0]    ptr_r;
    logic [NUM_CH-1:0]   sel_oh_r;
    logic [ADDR_W-1:0]   addr_r;
    logic [DATA_W-1:0]   dq_out_r;
    logic                dq_oe_r;
    logic                we_n_r;
    logic                oe_n_r;
    logic                ce_n_r;
    logic                ub_n_r;
    logic                lb_n_r;
    logic [NUM_CH-1:0]   gnt_r;
    logic [NUM_CH-1:0]   rd_valid_r;
    logic [DATA_W-1:0]   rdata_r;

    logic [NUM_CH-1:0]   win_s;
    logic [PTR_W-1:0]    win_idx_s;
    logic [ADDR_W-1:0]   sel_addr_s;
    logic [DATA_W-1:0]   sel_wdata_s;
    logic [BE_W-1:0]     sel_be_s;
    logic                sel_we_s;

    sram_rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
        .req    (iREQ),
        .ptr    (ptr_r),
        .winner (win_s)
    );

    // One-hot winner to channel index, used for command muxing and the next pointer.
    always_comb begin
        win_idx_s = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (win_s[c]) begin
                win_idx_s = PTR_W'(c);
            end else begin
                win_idx_s = win_idx_s;
            end
        end
    end

    assign sel_addr_s  = iADDR[int'(win_idx_s)*ADDR_W +: ADDR_W];
    assign sel_wdata_s = iWDATA[int'(win_idx_s)*DATA_W +: DATA_W];
    assign sel_be_s    = iBE[int'(win_idx_s)*BE_W +: BE_W];
    assign sel_we_s    = iWE[win_idx_s];

    // Access sequencer; every SRAM pin is driven straight from a flop.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_r    <= ST_IDLE;
            ptr_r      <= PTR_RST;
            sel_oh_r   <= '0;
            addr_r     <= '0;
            dq_out_r   <= '0;
            dq_oe_r    <= 1'b0;
            we_n_r     <= 1'b1;
            oe_n_r     <= 1'b1;
            ce_n_r     <= 1'b1;
            ub_n_r     <= 1'b1;
            lb_n_r     <= 1'b1;
            gnt_r      <= '0;
            rd_valid_r <= '0;
            rdata_r    <= '0;
        end else begin
            ce_n_r     <= 1'b0;
            gnt_r      <= '0;
            rd_valid_r <= '0;
            case (state_r)
                ST_IDLE: begin
                    if (|win_s) begin
                        ptr_r    <= win_idx_s;
                        sel_oh_r <= win_s;
                        gnt_r    <= win_s;
                        addr_r   <= sel_addr_s;
                        if (sel_we_s) begin
                            state_r  <= ST_WR;
                            we_n_r   <= 1'b0;
                            dq_oe_r  <= 1'b1;
                            dq_out_r <= sel_wdata_s;
                            ub_n_r   <= ~sel_be_s[1];
                            lb_n_r   <= ~sel_be_s[0];
                        end else begin
                            state_r <= ST_RD;
                            oe_n_r  <= 1'b0;
                            ub_n_r  <= 1'b0;
                            lb_n_r  <= 1'b0;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_WR: begin
                    state_r <= ST_WR_HOLD;
                    we_n_r  <= 1'b1;
                end
                ST_WR_HOLD: begin
                    state_r <= ST_IDLE;
                    dq_oe_r <= 1'b0;
                    ub_n_r  <= 1'b1;
                    lb_n_r  <= 1'b1;
                end
                ST_RD: begin
                    state_r    <= ST_IDLE;
                    oe_n_r     <= 1'b1;
                    ub_n_r     <= 1'b1;
                    lb_n_r     <= 1'b1;
                    rdata_r    <= ioSRAM_DQ;
                    rd_valid_r <= sel_oh_r;
                end
                default: begin
                    state_r <= ST_IDLE;
                    we_n_r  <= 1'b1;
                    oe_n_r  <= 1'b1;
                    dq_oe_r <= 1'b0;
                    ub_n_r  <= 1'b1;
                    lb_n_r  <= 1'b1;
                end
            endcase
        end
    end

    assign ioSRAM_DQ  = dq_oe_r ? dq_out_r : {DATA_W{1'bz}};
    assign oSRAM_ADDR = addr_r;
    assign oSRAM_WE_N = we_n_r;
    assign oSRAM_OE_N = oe_n_r;
    assign oSRAM_CE_N = ce_n_r;
    assign oSRAM_UB_N = ub_n_r;
    assign oSRAM_LB_N = lb_n_r;
    assign oGNT       = gnt_r;
    assign oRD_VALID  = rd_valid_r;
    assign oRDATA     = rdata_r;

endmodule
